// File: rtl/logicshifter_l2h_gate_sequencer.sv
// Power-up, dead-time and shutdown sequencer for the 2-bit low-to-high gate logic shifter.
// Optional minimum on-time per bit is enabled by defining LSSEQ_MIN_ON_EN.
module logicshifter_l2h_gate_sequencer #(
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 16,
  parameter int MIN_ON_CYC = 4
) (
  input  logic             CELCLK,
  input  logic             CELRSTN,
  input  logic             drv_en,
  input  logic             cmd_top,
  input  logic             cmd_bot,
  input  logic [CNT_W-1:0] dt_cfg,
  output logic             ls_enable,
  output logic [1:0]       ls_in,
  output logic             ready,
  output logic             overlap_err
);

  typedef enum logic [2:0] {
    S_OFF, S_SETTLE, S_IDLE, S_DEAD, S_TOP_ON, S_BOT_ON, S_DRAIN
  } state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, dt_load;
  logic             both, top_req, bot_req, hold_ok;

  assign both    = cmd_top & cmd_bot;
  assign top_req = cmd_top & ~cmd_bot;
  assign bot_req = cmd_bot & ~cmd_top;
  // Counter holds remaining cycles minus one, so a dt_cfg of 0 still yields one dead cycle.
  assign dt_load = (dt_cfg == '0) ? '0 : dt_cfg - CNT_W'(1);

`ifdef LSSEQ_MIN_ON_EN
  logic [CNT_W-1:0] mon, mon_nxt;
  assign hold_ok = (mon == '0);

  always_comb begin
    mon_nxt = (mon != '0) ? mon - CNT_W'(1) : mon;
    if ((nxt == S_TOP_ON || nxt == S_BOT_ON) && nxt != state)
      mon_nxt = CNT_W'(MIN_ON_CYC - 1);
  end

  always_ff @(posedge CELCLK or negedge CELRSTN)
    if (!CELRSTN) mon <= '0;
    else          mon <= mon_nxt;
`else
  logic unused_min_on;
  assign unused_min_on = ^MIN_ON_CYC;
  assign hold_ok       = 1'b1;
`endif

  always_comb begin
    nxt     = state;
    cnt_nxt = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    case (state)
      S_OFF:
        if (drv_en) begin nxt = S_SETTLE; cnt_nxt = CNT_W'(SETTLE_CYC - 1); end
      S_SETTLE:
        if (!drv_en)         nxt = S_OFF;
        else if (cnt == '0)  nxt = S_IDLE;
      S_IDLE:
        if (!drv_en)         begin nxt = S_DRAIN; cnt_nxt = dt_load; end
        else if (top_req)    nxt = S_TOP_ON;
        else if (bot_req)    nxt = S_BOT_ON;
      S_DEAD:
        if (!drv_en)         begin nxt = S_DRAIN; cnt_nxt = dt_load; end
        else if (cnt == '0) begin
          if (top_req)       nxt = S_TOP_ON;
          else if (bot_req)  nxt = S_BOT_ON;
          else               nxt = S_IDLE;
        end
      S_TOP_ON:
        if (!drv_en)         begin nxt = S_DRAIN; cnt_nxt = dt_load; end
        else if (both || (!cmd_top && hold_ok)) begin nxt = S_DEAD; cnt_nxt = dt_load; end
      S_BOT_ON:
        if (!drv_en)         begin nxt = S_DRAIN; cnt_nxt = dt_load; end
        else if (both || (!cmd_bot && hold_ok)) begin nxt = S_DEAD; cnt_nxt = dt_load; end
      S_DRAIN:
        if (cnt == '0)       nxt = S_OFF;
      default:               nxt = S_OFF;
    endcase
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state       <= S_OFF;
      cnt         <= '0;
      ls_enable   <= 1'b0;
      ls_in       <= 2'b00;
      ready       <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= cnt_nxt;
      // Outputs decode the next state so they land on the same edge as the transition.
      ls_enable   <= (nxt != S_OFF);
      ls_in       <= {nxt == S_TOP_ON, nxt == S_BOT_ON};
      ready       <= (nxt == S_IDLE) || (nxt == S_TOP_ON) || (nxt == S_BOT_ON);
      overlap_err <= (nxt == S_OFF) ? 1'b0 : (overlap_err | (both & (state != S_OFF)));
    end
  end

endmodule
